// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and default constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_PARITY_EN    = 0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uartState_t;

    // True for the states that put a timed bit on the serial line.
    function automatic logic isBitState(input uartState_t s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial/status outputs of the transmitter.
// master = transmitter side, slave = FIFO / line-receiver side.
interface fifo_uart_tx_if
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_ena;
    logic                  tx;
    logic                  busy;
    logic                  tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_ena,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_ena,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: pulses tick_o on the last clk of every serial bit.
module baud_tick_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && !clr_i && (cnt_q == LAST);

    // Count within a bit and restart at each boundary, so a bit never wraps early.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops characters from an upstream synchronous FIFO
// and sends them as start / data (LSB first) / optional even parity / stop.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = DEF_PARITY_EN
) (
    input logic           clk,
    input logic           rst,
    fifo_uart_tx_if.master bus
);
    localparam int              IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uartState_t            state_q,  state_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic                  parity_q, parity_d;
    logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
    logic                  tx_q,     tx_d;
    logic                  armed_q;
    logic                  tick;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == LOAD),
        .en_i   (isBitState(state_q)),
        .tick_o (tick)
    );

    assign bus.fifo_rd_ena = (state_q == READ);
    assign bus.busy        = (state_q != IDLE);
    assign bus.tx_done     = (state_q == STOP) && tick;
    assign bus.tx          = tx_q;

    // Next state, shift/parity capture and the line value for the coming cycle.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        bitIdx_d = bitIdx_q;
        tx_d     = 1'b1;
        case (state_q)
            IDLE: begin
                if (armed_q && !bus.fifo_empty) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d  = bus.fifo_data;
                parity_d = ^bus.fifo_data;
                bitIdx_d = '0;
                state_d  = START;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitIdx_q == LAST_IDX) begin
                        bitIdx_d = '0;
                        state_d  = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = bus.fifo_empty ? IDLE : READ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; armed_q holds off the first pop by one edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bitIdx_q <= '0;
            tx_q     <= 1'b1;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            bitIdx_q <= bitIdx_d;
            tx_q     <= tx_d;
            armed_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance without parity, one with.
module tb_fifo_uart_tx;
    localparam int DW  = 8;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus0 ();
    fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus1 ();

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int total        = 0;
    int bad          = 0;
    int rdCnt0       = 0;
    int rdCnt1       = 0;
    int doneCnt0     = 0;
    int doneCnt1     = 0;
    int rdWhileEmpty = 0;
    int pushed0      = 0;
    int pushed1      = 0;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        int          nBits;
        logic [0:10] frame;
    } vec_t;

    vec_t vecs[10];

    // Synchronous FIFO model: registered read data and registered empty flag.
    always @(posedge clk) begin
        if (bus0.fifo_rd_ena && q0.size() > 0) bus0.fifo_data <= q0.pop_front();
        bus0.fifo_empty <= (q0.size() == 0);
        if (bus1.fifo_rd_ena && q1.size() > 0) bus1.fifo_data <= q1.pop_front();
        bus1.fifo_empty <= (q1.size() == 0);
    end

    // Count pops and completions, and flag any pop request against an empty FIFO.
    always @(negedge clk) begin
        if (bus0.fifo_rd_ena) rdCnt0++;
        if (bus1.fifo_rd_ena) rdCnt1++;
        if (bus0.tx_done) doneCnt0++;
        if (bus1.tx_done) doneCnt1++;
        if ((bus0.fifo_rd_ena && bus0.fifo_empty) || (bus1.fifo_rd_ena && bus1.fifo_empty))
            rdWhileEmpty++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] data);
        if (sel != 0) begin
            q1.push_back(data);
            pushed1++;
        end else begin
            q0.push_back(data);
            pushed0++;
        end
    endtask

    function automatic logic selTx(input int sel);
        return (sel != 0) ? bus1.tx : bus0.tx;
    endfunction

    function automatic logic selDone(input int sel);
        return (sel != 0) ? bus1.tx_done : bus0.tx_done;
    endfunction

    // Wait for the start bit, then compare every cycle of the frame.
    task automatic runFrame(input int sel, input int nBits, input logic [0:10] expFrame,
                            input string name, output int gap);
        int txErr;
        int doneErr;
        gap = 0;
        @(negedge clk);
        while (selTx(sel) !== 1'b0 && gap < 60) begin
            gap++;
            @(negedge clk);
        end
        if (selTx(sel) !== 1'b0) begin
            checkOutput({name, " start bit timeout"}, 32'(selTx(sel)), 32'd0);
            return;
        end
        txErr   = 0;
        doneErr = 0;
        for (int k = 0; k < nBits * CPB; k++) begin
            if (k > 0) @(negedge clk);
            if (selTx(sel) !== expFrame[k / CPB]) txErr++;
            if (selDone(sel) !== (k == nBits * CPB - 1)) doneErr++;
        end
        checkOutput({name, " tx bit errors"}, 32'(txErr), 32'd0);
        checkOutput({name, " tx_done errors"}, 32'(doneErr), 32'd0);
    endtask

    initial begin
        int gap;
        int rdBefore;
        int doneBefore;
        int errs;

        // Frame bits in transmit order: start_data(LSB first)_parity-or-stop_stop-or-pad
        vecs[0] = '{0, 8'hA5, 10, 11'b0_10100101_1_1};
        vecs[1] = '{0, 8'h00, 10, 11'b0_00000000_1_1};
        vecs[2] = '{0, 8'hFF, 10, 11'b0_11111111_1_1};
        vecs[3] = '{0, 8'h01, 10, 11'b0_10000000_1_1};
        vecs[4] = '{0, 8'h80, 10, 11'b0_00000001_1_1};
        vecs[5] = '{0, 8'h3C, 10, 11'b0_00111100_1_1};
        vecs[6] = '{1, 8'h07, 11, 11'b0_11100000_1_1};
        vecs[7] = '{1, 8'h03, 11, 11'b0_11000000_0_1};
        vecs[8] = '{1, 8'hA5, 11, 11'b0_10100101_0_1};
        vecs[9] = '{1, 8'h80, 11, 11'b0_00000001_1_1};

        // Reset held with a non-empty FIFO: line idle, no pop, not busy.
        rst = 1'b1;
        #1 rst = 1'b0;
        applyStimulus(0, 8'hA5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("reset c%0d tx", c), 32'(bus0.tx), 32'd1);
            checkOutput($sformatf("reset c%0d rd_ena", c), 32'(bus0.fifo_rd_ena), 32'd0);
            checkOutput($sformatf("reset c%0d busy", c), 32'(bus0.busy), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rd_ena after 1st edge", 32'(bus0.fifo_rd_ena), 32'd0);
        @(negedge clk);
        checkOutput("rd_ena after 2nd edge", 32'(bus0.fifo_rd_ena), 32'd1);
        runFrame(0, vecs[0].nBits, vecs[0].frame, "post-reset A5", gap);
        @(negedge clk);
        checkOutput("post-reset idle busy", 32'(bus0.busy), 32'd0);

        // Table of single characters on both instances.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].data);
            runFrame(vecs[i].sel, vecs[i].nBits, vecs[i].frame, $sformatf("vec%0d", i), gap);
            @(negedge clk);
            checkOutput($sformatf("vec%0d idle busy", i), 32'(vecs[i].sel != 0 ? bus1.busy : bus0.busy), 32'd0);
            checkOutput($sformatf("vec%0d idle tx", i), 32'(selTx(vecs[i].sel)), 32'd1);
        end

        // Back-to-back characters: exactly two high cycles between frames.
        #1;
        rdBefore   = rdCnt0;
        doneBefore = doneCnt0;
        applyStimulus(0, 8'h00);
        applyStimulus(0, 8'hFF);
        runFrame(0, 10, vecs[1].frame, "b2b first", gap);
        runFrame(0, 10, vecs[2].frame, "b2b second", gap);
        checkOutput("b2b gap cycles", 32'(gap), 32'd2);
        @(negedge clk);
        #1;
        checkOutput("b2b rd_ena pulses", 32'(rdCnt0 - rdBefore), 32'd2);
        checkOutput("b2b tx_done pulses", 32'(doneCnt0 - doneBefore), 32'd2);
        checkOutput("b2b idle busy", 32'(bus0.busy), 32'd0);

        // Empty FIFO for 100 cycles: nothing happens.
        errs = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus0.fifo_rd_ena !== 1'b0 || bus0.tx !== 1'b1 || bus0.busy !== 1'b0) errs++;
        end
        checkOutput("empty fifo idle errors", 32'(errs), 32'd0);

        // Reset during data bit 3 of 0x5A aborts the frame at once.
        @(negedge clk);
        #1;
        doneBefore = doneCnt0;
        applyStimulus(0, 8'h5A);
        gap = 0;
        @(negedge clk);
        while (bus0.tx !== 1'b0 && gap < 60) begin
            gap++;
            @(negedge clk);
        end
        checkOutput("midreset start bit", 32'(bus0.tx), 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("midreset data bit2", 32'(bus0.tx), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("midreset busy before", 32'(bus0.busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("midreset tx", 32'(bus0.tx), 32'd1);
        checkOutput("midreset busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        rst  = 1'b1;
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus0.busy !== 1'b0 || bus0.tx !== 1'b1) errs++;
        end
        #1;
        checkOutput("midreset stays idle", 32'(errs), 32'd0);
        checkOutput("midreset no tx_done", 32'(doneCnt0 - doneBefore), 32'd0);

        // Totals over the whole run.
        checkOutput("dut0 total pops", 32'(rdCnt0), 32'(pushed0));
        checkOutput("dut1 total pops", 32'(rdCnt1), 32'(pushed1));
        checkOutput("dut0 total tx_done", 32'(doneCnt0), 32'(pushed0 - 1));
        checkOutput("dut1 total tx_done", 32'(doneCnt1), 32'(pushed1));
        checkOutput("rd_ena while empty", 32'(rdWhileEmpty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
